keypad_bcd_entry: RTL and testbench

//  Input-side counterpart of the 4-digit 7-seg display driver: scans a 4x4 matrix keypad,

---
 rtl/keypad_bcd_entry.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_bcd_entry.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/keypad_bcd_entry.sv
// rtl/keypad_bcd_entry.sv - 4x4 keypad scanner, debouncer and 4-digit BCD entry register
//
// Scans a 4x4 active-low matrix keypad and debounces complete scans. Accepted decimal
// keys are shifted into a 4-digit BCD word. A clears the word and B is backspace.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN. When it is defined, a held key
// repeats every REPEAT_SCANS scans.
//
// Ports:
//   CLK_50M    in   system clock
//   RST        in   synchronous active-low reset
//   key_row    in   [3:0] keypad rows, active-low, asynchronous to CLK_50M
//   key_col    out  [3:0] column drive, active-low, one-hot-low
//   data       out  [15:0] BCD entry, [15:12] is the most significant digit
//   key_valid  out  one-cycle pulse per accepted key event
//   key_code   out  [3:0] code of the last accepted key
//   digit_cnt  out  [2:0] number of entered digits, 0..4
module keypad_bcd_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic [3:0]  key_row,
  output logic [3:0]  key_col,
  output logic [15:0] data,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [2:0]  digit_cnt
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx;
  logic [1:0]       col_nxt;
  logic [3:0]       row_s1, row_s2;
  logic [15:0]      hits;       // pressed bits of the scan in progress, idx = row*4+col
  logic [15:0]      full_hits;  // hits with column 3 taken from the live sample
  logic             tick, scan_done;
  logic             res_valid;
  logic [3:0]       res_idx;
  logic [3:0]       res_code;
  logic             accept;

  state_t           state;
  logic [3:0]       cand;
  logic [3:0]       cnt;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  logic [REP_W-1:0] rep_cnt;
`endif

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:  key_map = 4'h1;
      4'd1:  key_map = 4'h2;
      4'd2:  key_map = 4'h3;
      4'd3:  key_map = 4'hA;
      4'd4:  key_map = 4'h4;
      4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h6;
      4'd7:  key_map = 4'hB;
      4'd8:  key_map = 4'h7;
      4'd9:  key_map = 4'h8;
      4'd10: key_map = 4'h9;
      4'd11: key_map = 4'hC;
      4'd12: key_map = 4'hE;
      4'd13: key_map = 4'h0;
      4'd14: key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign scan_done = tick && (col_idx == 2'd3);
  assign col_nxt   = tick ? col_idx + 2'd1 : col_idx;

  always_ff @(posedge CLK_50M) begin
    if (!RST) begin
      row_s1  <= 4'b1111;
      row_s2  <= 4'b1111;
      div_cnt <= '0;
      col_idx <= 2'd0;
      hits    <= '0;
      key_col <= 4'b1111;
    end else begin
      row_s1  <= key_row;
      row_s2  <= row_s1;
      key_col <= ~(4'b0001 << col_nxt);
      if (tick) begin
        div_cnt <= '0;
        col_idx <= col_nxt;
        for (int r = 0; r < 4; r++) hits[{2'(r), col_idx}] <= ~row_s2[r];
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Column 3 is sampled on the scan_done tick itself, so its bits are merged live.
  always_comb begin
    full_hits = hits;
    for (int r = 0; r < 4; r++) full_hits[{2'(r), 2'd3}] = ~row_s2[r];
    res_valid = 1'b0;
    res_idx   = 4'd0;
    // Descending loop so the lowest pressed index wins.
    for (int i = 15; i >= 0; i--) begin
      if (full_hits[i]) begin
        res_valid = 1'b1;
        res_idx   = 4'(i);
      end
    end
    res_code = key_map(res_idx);
  end

  always_comb begin
    accept = 1'b0;
    if (scan_done && res_valid) begin
      case (state)
        IDLE:  accept = (DEBOUNCE_SCANS == 1);
        PRESS: accept = (res_idx == cand) && (({1'b0, cnt} + 5'd1) == 5'(DEBOUNCE_SCANS));
`ifdef KEYPAD_AUTOREPEAT_EN
        HELD:  accept = (res_idx == cand) &&
                        (({1'b0, rep_cnt} + 1'b1) == (REP_W + 1)'(REPEAT_SCANS));
`endif
        default: accept = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      data      <= 16'h0000;
      digit_cnt <= 3'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= res_code;
        if (res_code <= 4'd9) begin
          data      <= {data[11:0], res_code};
          digit_cnt <= (digit_cnt == 3'd4) ? 3'd4 : digit_cnt + 3'd1;
        end else if (res_code == 4'hA) begin
          data      <= 16'h0000;
          digit_cnt <= 3'd0;
        end else if (res_code == 4'hB) begin
          data      <= {4'h0, data[15:4]};
          digit_cnt <= (digit_cnt == 3'd0) ? 3'd0 : digit_cnt - 3'd1;
        end
      end

      if (scan_done) begin
        case (state)
          IDLE: if (res_valid) begin
            cand  <= res_idx;
            cnt   <= 4'd1;
            state <= (DEBOUNCE_SCANS == 1) ? HELD : PRESS;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end
          PRESS: if (res_valid && res_idx == cand) begin
            cnt <= cnt + 4'd1;
            if (accept) begin
              state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt <= '0;
`endif
            end
          end else begin
            state <= IDLE;
          end
          HELD: if (!res_valid) begin
            cnt   <= 4'd1;
            state <= (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
          end else if (res_idx == cand) begin
            rep_cnt <= accept ? '0 : rep_cnt + 1'b1;
`endif
          end
          RELEASE: if (res_valid) begin
            state <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            cnt <= cnt + 4'd1;
            if (({1'b0, cnt} + 5'd1) == 5'(DEBOUNCE_SCANS)) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// tb/tb_keypad_bcd_entry.sv - directed self-checking bench for keypad_bcd_entry
module tb_keypad_bcd_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_row;
  logic [3:0]  key_col;
  logic [15:0] data;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [2:0]  digit_cnt;

  logic [15:0] press = 16'h0000;  // keys held down, idx = row*4+col
  logic [3:0]  prev_col = 4'b1111;
  int          checks = 0;
  int          errors = 0;
  int          kv_count = 0;
  int          snap;

  localparam int SCAN = 16;  // cycles per full scan with SCAN_DIV=4

  always #5 clk = ~clk;

  keypad_bcd_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2), .REPEAT_SCANS(3)) dut (
    .CLK_50M(clk), .RST(rst_n), .key_row(key_row), .key_col(key_col),
    .data(data), .key_valid(key_valid), .key_code(key_code), .digit_cnt(digit_cnt)
  );

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    key_row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  always @(negedge clk) if (rst_n && key_valid) kv_count++;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Return in the first cycle of a column-0 dwell.
  task automatic align();
    for (int k = 0; k < 40; k++) begin
      prev_col = key_col;
      @(negedge clk);
      if (key_col == 4'b1110 && prev_col == 4'b0111) return;
    end
    checks++; errors++;
    $display("FAIL align: scan wrap never seen, key_col=%b", key_col);
  endtask

  task automatic hold(input logic [15:0] m, input int nscans);
    align();
    press = m;
    wait_cycles(SCAN * nscans);
    press = 16'h0000;
    wait_cycles(SCAN * 3);
  endtask

  task automatic tap(input int idx);
    hold(16'(1) << idx, 3);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4];
    exp_col = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    rst_n = 1'b0;
    press = 16'h0020;
    wait_cycles(6);
    checks++; if (key_col !== 4'b1111) begin errors++; $display("FAIL reset_col got %b exp 1111", key_col); end
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", data); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %b exp 0", key_valid); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", digit_cnt); end
    checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h exp 0", key_code); end
    press = 16'h0000;
    rst_n = 1'b1;
    wait_cycles(2);
    checks++; if (key_col !== 4'b1110) begin errors++; $display("FAIL first_col got %b exp 1110", key_col); end
    for (int k = 0; k < 8 && key_col !== 4'b1101; k++) @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (key_col !== exp_col[j/4]) begin
        errors++; $display("FAIL col_seq[%0d] got %b exp %b", j, key_col, exp_col[j/4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    snap = kv_count;
    hold(16'h0020, 5);  // '5'
    checks++; if (kv_count - snap !== 1) begin errors++; $display("FAIL single_events got %0d exp 1", kv_count - snap); end
    checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL single_code got %h exp 5", key_code); end
    checks++; if (data !== 16'h0005) begin errors++; $display("FAIL single_data got %h exp 0005", data); end
    checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", digit_cnt); end
  endtask

  task automatic test_shift();
    tap(3);  // A
    snap = kv_count;
    tap(0); tap(1); tap(2); tap(4); tap(5);  // 1 2 3 4 5
    checks++; if (kv_count - snap !== 5) begin errors++; $display("FAIL shift_events got %0d exp 5", kv_count - snap); end
    checks++; if (data !== 16'h2345) begin errors++; $display("FAIL shift_data got %h exp 2345", data); end
    checks++; if (digit_cnt !== 3'd4) begin errors++; $display("FAIL shift_cnt got %0d exp 4", digit_cnt); end
  endtask

  task automatic test_bounce();
    snap = kv_count;
    hold(16'h0100, 1);  // '7' for one scan only
    checks++; if (kv_count - snap !== 0) begin errors++; $display("FAIL bounce_events got %0d exp 0", kv_count - snap); end
    checks++; if (data !== 16'h2345) begin errors++; $display("FAIL bounce_data got %h exp 2345", data); end
    align();
    press = 16'h0100;
    wait_cycles(SCAN * 3);
    press = 16'h0000;
    wait_cycles(SCAN);
    press = 16'h0100;
    wait_cycles(SCAN * 3);
    press = 16'h0000;
    wait_cycles(SCAN * 3);
    checks++; if (kv_count - snap !== 1) begin errors++; $display("FAIL rel_bounce_events got %0d exp 1", kv_count - snap); end
    checks++; if (data !== 16'h3457) begin errors++; $display("FAIL rel_bounce_data got %h exp 3457", data); end
  endtask

  task automatic test_edit();
    tap(3); tap(0); tap(1); tap(7);  // A 1 2 B
    checks++; if (data !== 16'h0001) begin errors++; $display("FAIL bksp_data got %h exp 0001", data); end
    checks++; if (digit_cnt !== 3'd1) begin errors++; $display("FAIL bksp_cnt got %0d exp 1", digit_cnt); end
    tap(3);
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL clear_data got %h exp 0000", data); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL clear_cnt got %0d exp 0", digit_cnt); end
    tap(7);
    checks++; if (data !== 16'h0000) begin errors++; $display("FAIL bksp0_data got %h exp 0000", data); end
    checks++; if (digit_cnt !== 3'd0) begin errors++; $display("FAIL bksp0_cnt got %0d exp 0", digit_cnt); end
    checks++; if (key_code !== 4'hB) begin errors++; $display("FAIL bksp0_code got %h exp B", key_code); end
  endtask

  task automatic test_multi_and_func();
    hold(16'h0401, 3);  // '1' and '9' together
    checks++; if (key_code !== 4'h1) begin errors++; $display("FAIL multi_code got %h exp 1", key_code); end
    checks++; if (data !== 16'h0001) begin errors++; $display("FAIL multi_data got %h exp 0001", data); end
    snap = kv_count;
    tap(11);  // C
    checks++; if (kv_count - snap !== 1) begin errors++; $display("FAIL func_events got %0d exp 1", kv_count - snap); end
    checks++; if (key_code !== 4'hC) begin errors++; $display("FAIL func_code got %h exp C", key_code); end
    checks++; if (data !== 16'h0001 || digit_cnt !== 3'd1) begin
      errors++; $display("FAIL func_data got %h/%0d exp 0001/1", data, digit_cnt);
    end
  endtask

  task automatic test_long_hold();
    tap(3);
    snap = kv_count;
    hold(16'h0002, 11);  // '2'
`ifdef KEYPAD_AUTOREPEAT_EN
    checks++; if (kv_count - snap !== 4) begin errors++; $display("FAIL repeat_events got %0d exp 4", kv_count - snap); end
    checks++; if (data !== 16'h2222) begin errors++; $display("FAIL repeat_data got %h exp 2222", data); end
`else
    checks++; if (kv_count - snap !== 1) begin errors++; $display("FAIL hold_events got %0d exp 1", kv_count - snap); end
    checks++; if (data !== 16'h0002) begin errors++; $display("FAIL hold_data got %h exp 0002", data); end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_shift();
    test_bounce();
    test_edit();
    test_multi_and_func();
    test_long_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
